// File: rtl/bridge_egress_arb.sv
// rtl/bridge_egress_arb.sv - packet-granular round-robin egress arbiter (optional stall timeout: BRIDGE_ARB_TIMEOUT_EN)
module bridge_egress_arb #(
   parameter int NPORT   = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NPORT-1:0]       p_srdy,
   output logic [NPORT-1:0]       p_drdy,
   input  logic [NPORT*WIDTH-1:0] p_data,
   input  logic [NPORT*2-1:0]     p_code,
   output logic                   c_srdy,
   input  logic                   c_drdy,
   output logic [WIDTH-1:0]       c_data,
   output logic [1:0]             c_code,
   output logic [NPORT-1:0]       grant
);

   localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {ST_IDLE, ST_XFER} state_t;

   state_t           r_state, w_state_nxt;
   logic [IW-1:0]    r_owner, w_owner_nxt;
   logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
   logic [NPORT-1:0] r_grant, w_grant_nxt;

   logic             w_found;
   logic [IW-1:0]    w_winner;
   logic             w_own_srdy;
   logic [WIDTH-1:0] w_own_data;
   logic [1:0]       w_own_code;
   logic             w_xfer;
   logic             w_end;
   logic             w_timeout;
   logic [IW-1:0]    w_owner_inc;

   assign grant       = r_grant;
   assign w_owner_inc = (r_owner == IW'(NPORT - 1)) ? '0 : r_owner + 1'b1;

   // round-robin search: indices at/above rr_ptr first, then wrap to the low ones
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (!w_found && p_srdy[i] && (IW'(i) >= r_rr_ptr)) begin
            w_found  = 1'b1;
            w_winner = IW'(i);
         end
      end
      for (int i = 0; i < NPORT; i++) begin
         if (!w_found && p_srdy[i]) begin
            w_found  = 1'b1;
            w_winner = IW'(i);
         end
      end
   end

   // select the current owner's stream
   always_comb begin
      w_own_srdy = 1'b0;
      w_own_data = '0;
      w_own_code = 2'b00;
      for (int i = 0; i < NPORT; i++) begin
         if (r_owner == IW'(i)) begin
            w_own_srdy = p_srdy[i];
            w_own_data = p_data[i*WIDTH +: WIDTH];
            w_own_code = p_code[i*2 +: 2];
         end
      end
   end

`ifdef BRIDGE_ARB_TIMEOUT_EN
   logic [15:0] r_stall;

   assign w_timeout = (r_state == ST_XFER) && (r_stall == 16'(TIMEOUT));

   // count idle cycles of the owner mid-packet; held at the limit until the BADEOP is taken
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall <= '0;
      end else if (r_state != ST_XFER) begin
         r_stall <= '0;
      end else if (w_timeout) begin
         if (c_drdy) r_stall <= '0;
      end else if (w_own_srdy) begin
         if (c_drdy) r_stall <= '0;
      end else begin
         r_stall <= r_stall + 16'd1;
      end
   end
`else
   // no stall counter: a mid-packet stall lasts as long as the owner holds off
   assign w_timeout = (TIMEOUT < 0);
`endif

   // egress pass-through; everything is quiet in IDLE and while reset is held
   always_comb begin
      c_srdy = 1'b0;
      c_data = '0;
      c_code = 2'b00;
      p_drdy = '0;
      w_xfer = 1'b0;
      w_end  = 1'b0;
      if ((r_state == ST_XFER) && reset) begin
         if (w_timeout) begin
            c_srdy = 1'b1;
            c_code = 2'b11;
            w_end  = c_drdy;
         end else begin
            c_srdy = w_own_srdy;
            c_data = w_own_data;
            c_code = w_own_code;
            p_drdy = r_grant & {NPORT{c_drdy}};
            w_xfer = w_own_srdy && c_drdy;
            w_end  = w_xfer && w_own_code[1];
         end
      end
   end

   // next-state: grant a winner from IDLE, release on EOP/BADEOP transfer
   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      w_grant_nxt  = r_grant;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_XFER;
               w_owner_nxt = w_winner;
               w_grant_nxt = NPORT'(1) << w_winner;
            end
         end
         ST_XFER: begin
            if (w_end) begin
               w_state_nxt  = ST_IDLE;
               w_grant_nxt  = '0;
               w_rr_ptr_nxt = w_owner_inc;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_grant  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_grant  <= w_grant_nxt;
      end
   end

endmodule

// File: tb/tb_bridge_egress_arb.sv
// tb/tb_bridge_egress_arb.sv - directed self-checking bench for bridge_egress_arb
module tb_bridge_egress_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] p_srdy;
   logic [3:0] p_drdy;
   logic [31:0] p_data;
   logic [7:0] p_code;
   logic       c_srdy;
   logic       c_drdy;
   logic [7:0] c_data;
   logic [1:0] c_code;
   logic [3:0] grant;

   int checks = 0;
   int errors = 0;

   bridge_egress_arb #(.NPORT(4), .WIDTH(8), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_code(p_code),
      .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_code(c_code),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic s, input logic [7:0] d, input logic [1:0] c);
      p_srdy[i]        = s;
      p_data[i*8 +: 8] = d;
      p_code[i*2 +: 2] = c;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      p_srdy = 4'hF;
      p_data = 32'hDEADBEEF;
      p_code = 8'h00;
      c_drdy = 1'b1;
      step();
      step();
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
      checks++; if (c_srdy !== 1'b0) begin errors++; $display("FAIL reset_c_srdy got %b want 0", c_srdy); end
      checks++; if (c_data !== 8'h00 || c_code !== 2'b00) begin errors++; $display("FAIL reset_c_data got %h/%b want 00/00", c_data, c_code); end
      checks++; if (p_drdy !== 4'b0000) begin errors++; $display("FAIL reset_p_drdy got %b want 0000", p_drdy); end
      p_srdy = 4'h0;
      reset  = 1'b1;
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_idle_grant got %b want 0000", grant); end
   endtask

   task automatic test_single();
      logic [7:0] dat [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      logic [1:0] cod [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
      c_drdy = 1'b1;
      drive(2, 1'b1, dat[0], cod[0]);
      #1;
      checks++; if (c_srdy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_bubble got srdy=%b grant=%b want 0/0000", c_srdy, grant); end
      step();
      for (int w = 0; w < 4; w++) begin
         drive(2, 1'b1, dat[w], cod[w]);
         #1;
         checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant w%0d got %b want 0100", w, grant); end
         checks++; if (c_srdy !== 1'b1 || c_data !== dat[w] || c_code !== cod[w]) begin
            errors++; $display("FAIL single_word w%0d got %b/%h/%b want 1/%h/%b", w, c_srdy, c_data, c_code, dat[w], cod[w]);
         end
         checks++; if (p_drdy !== 4'b0100) begin errors++; $display("FAIL single_p_drdy w%0d got %b want 0100", w, p_drdy); end
         step();
      end
      drive(2, 1'b0, 8'h00, 2'b00);
      #1;
      checks++; if (grant !== 4'b0000 || c_srdy !== 1'b0) begin errors++; $display("FAIL single_release got grant=%b srdy=%b want 0000/0", grant, c_srdy); end
      // rr_ptr is now 3: requester 3 beats requester 0
      drive(0, 1'b1, 8'h0E, 2'b10);
      drive(3, 1'b1, 8'h3E, 2'b10);
      step();
      checks++; if (grant !== 4'b1000 || c_data !== 8'h3E) begin errors++; $display("FAIL single_rr3 got grant=%b data=%h want 1000/3e", grant, c_data); end
      step();
      drive(0, 1'b0, 8'h00, 2'b00);
      drive(3, 1'b0, 8'h00, 2'b00);
      step();
   endtask

   task automatic test_round_robin();
      int cnt [4];
      int total [4] = '{6, 3, 3, 3};
      int exp_owner [5] = '{0, 1, 2, 3, 0};
      int tx_n;
      int p, w, o;
      logic [7:0] ed;
      logic [1:0] ec;
      cnt    = '{0, 0, 0, 0};
      tx_n   = 0;
      c_drdy = 1'b1;
      for (int cyc = 0; cyc < 30 && tx_n < 15; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (cnt[i] < total[i])
               drive(i, 1'b1, 8'(i*16 + cnt[i]), (cnt[i] % 3 == 0) ? 2'b00 : ((cnt[i] % 3 == 2) ? 2'b10 : 2'b01));
            else
               drive(i, 1'b0, 8'h00, 2'b00);
         end
         #1;
         if (c_srdy && c_drdy) begin
            p  = tx_n / 3;
            w  = tx_n % 3;
            o  = exp_owner[p];
            ed = 8'(o*16 + ((p == 4) ? 3 : 0) + w);
            ec = (w == 0) ? 2'b00 : ((w == 2) ? 2'b10 : 2'b01);
            checks++; if (cyc !== 1 + p*4 + w) begin errors++; $display("FAIL rr_timing word%0d got cycle %0d want %0d", tx_n, cyc, 1 + p*4 + w); end
            checks++; if (grant !== 4'(1 << o)) begin errors++; $display("FAIL rr_grant word%0d got %b want %b", tx_n, grant, 4'(1 << o)); end
            checks++; if (c_data !== ed || c_code !== ec) begin errors++; $display("FAIL rr_word%0d got %h/%b want %h/%b", tx_n, c_data, c_code, ed, ec); end
            tx_n++;
         end
         for (int i = 0; i < 4; i++) if (p_srdy[i] && p_drdy[i]) cnt[i]++;
         step();
      end
      checks++; if (tx_n !== 15) begin errors++; $display("FAIL rr_count got %0d want 15", tx_n); end
      p_srdy = 4'h0;
      step();
   endtask

   task automatic test_stall();
      c_drdy = 1'b1;
      drive(1, 1'b1, 8'h10, 2'b00);
      step();
      checks++; if (grant !== 4'b0010 || c_data !== 8'h10) begin errors++; $display("FAIL stall_grant got %b/%h want 0010/10", grant, c_data); end
      drive(0, 1'b1, 8'h5A, 2'b10);
      step();
      drive(1, 1'b0, 8'h00, 2'b00);
      for (int s = 0; s < 10; s++) begin
         #1;
         checks++; if (grant !== 4'b0010 || c_srdy !== 1'b0 || p_drdy[0] !== 1'b0) begin
            errors++; $display("FAIL stall_hold s%0d got grant=%b srdy=%b drdy0=%b want 0010/0/0", s, grant, c_srdy, p_drdy[0]);
         end
         step();
      end
      drive(1, 1'b1, 8'h11, 2'b01);
      #1;
      checks++; if (c_srdy !== 1'b1 || c_data !== 8'h11) begin errors++; $display("FAIL stall_resume got %b/%h want 1/11", c_srdy, c_data); end
      step();
      drive(1, 1'b1, 8'h12, 2'b10);
      step();
      drive(1, 1'b0, 8'h00, 2'b00);
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_bubble got %b want 0000", grant); end
      step();
      checks++; if (grant !== 4'b0001 || c_data !== 8'h5A || c_code !== 2'b10) begin
         errors++; $display("FAIL stall_next got %b/%h/%b want 0001/5a/10", grant, c_data, c_code);
      end
      step();
      drive(0, 1'b0, 8'h00, 2'b00);
      step();
   endtask

   task automatic test_backpressure();
      int cnt;
      logic [1:0] ec;
      cnt = 0;
      for (int cyc = 0; cyc < 40 && cnt < 5; cyc++) begin
         c_drdy = (cyc % 2 == 1);
         ec = (cnt == 0) ? 2'b00 : ((cnt == 4) ? 2'b10 : 2'b01);
         drive(3, 1'b1, 8'(8'hC0 + cnt), ec);
         #1;
         checks++; if (p_drdy !== ((cyc == 0) ? 4'b0000 : {c_drdy, 3'b000})) begin
            errors++; $display("FAIL bp_p_drdy cyc%0d got %b want drdy3=%b", cyc, p_drdy, c_drdy);
         end
         if (c_srdy && c_drdy) begin
            checks++; if (c_data !== 8'(8'hC0 + cnt) || c_code !== ec || cyc !== 1 + 2*cnt) begin
               errors++; $display("FAIL bp_word%0d got %h/%b at cyc %0d want %h/%b at %0d", cnt, c_data, c_code, cyc, 8'(8'hC0 + cnt), ec, 1 + 2*cnt);
            end
            cnt++;
         end
         step();
      end
      checks++; if (cnt !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", cnt); end
      drive(3, 1'b0, 8'h00, 2'b00);
      c_drdy = 1'b1;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_release got %b want 0000", grant); end
      step();
   endtask

   task automatic test_reset_mid();
      c_drdy = 1'b1;
      drive(2, 1'b1, 8'h77, 2'b10);
      step();
      step();
      drive(2, 1'b0, 8'h00, 2'b00);
      drive(0, 1'b1, 8'h10, 2'b00);
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_mid_grant got %b want 0001", grant); end
      step();
      drive(0, 1'b1, 8'h11, 2'b01);
      step();
      drive(0, 1'b1, 8'h12, 2'b01);
      reset = 1'b0;
      #1;
      checks++; if (c_srdy !== 1'b0 || p_drdy !== 4'b0000) begin errors++; $display("FAIL rst_mid_quiet got srdy=%b drdy=%b want 0/0000", c_srdy, p_drdy); end
      step();
      reset = 1'b1;
      drive(3, 1'b1, 8'h30, 2'b00);
      #1;
      checks++; if (grant !== 4'b0000 || c_srdy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got grant=%b srdy=%b want 0000/0", grant, c_srdy); end
      step();
      checks++; if (grant !== 4'b0001 || c_data !== 8'h12) begin errors++; $display("FAIL rst_mid_rearb got %b/%h want 0001/12", grant, c_data); end
      p_srdy = 4'h0;
      reset  = 1'b0;
      step();
      reset  = 1'b1;
      step();
   endtask

`ifdef BRIDGE_ARB_TIMEOUT_EN
   task automatic test_timeout();
      c_drdy = 1'b1;
      drive(2, 1'b1, 8'h20, 2'b00);
      step();
      step();
      drive(2, 1'b1, 8'h21, 2'b01);
      drive(3, 1'b1, 8'h33, 2'b10);
      step();
      drive(2, 1'b0, 8'h00, 2'b00);
      for (int s = 0; s < 8; s++) begin
         #1;
         checks++; if (c_srdy !== 1'b0 || grant !== 4'b0100) begin errors++; $display("FAIL to_stall s%0d got %b/%b want 0/0100", s, c_srdy, grant); end
         step();
      end
      checks++; if (c_srdy !== 1'b1 || c_code !== 2'b11 || c_data !== 8'h00 || p_drdy !== 4'b0000) begin
         errors++; $display("FAIL to_badeop got %b/%b/%h/%b want 1/11/00/0000", c_srdy, c_code, c_data, p_drdy);
      end
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_release got %b want 0000", grant); end
      step();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL to_next got %b want 1000", grant); end
      p_srdy = 4'h0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_backpressure();
      test_reset_mid();
`ifdef BRIDGE_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
